gray_to_yuv422_reg: RTL and testbench
=====================================

Name: gray_to_yuv422_reg

Overview:
Registered, parametrised successor to the combinational gray-to-YUV422 packer in the Format_Conv path. It converts a PPC-pixel grayscale AXI-Stream into YUV422 beats, with Y taken from the gray input and a programmable chroma value latched per frame. It sits between the stereo disparity/gray output and the video output pipeline. It adds a full-throughput 2-entry skid buffer, so timing is broken on both tdata and tready, plus a frame counter and optional line-length checking.

Parameters:
DATA_WIDTH, 8, bits per component.
PPC, 4, pixels per clock (1..8).
PAD_TO_3, 1, 1: output is 3*DATA_WIDTH*PPC wide with zero-filled upper part; 0: output is 2*DATA_WIDTH*PPC wide.
CHROMA_RESET, 2**(DATA_WIDTH-1), chroma value used after reset until the first SOF.
LINE_BEATS_W, 12, width of the line beat counter and cfg_line_beats.

Ports:
aclk  in  1  clock.
areset  in  1  asynchronous active-high reset.
cfg_chroma  in  DATA_WIDTH  chroma value; sampled on each accepted SOF beat.
s_axis_gray_tvalid  in  1  input valid.
s_axis_gray_tdata  in  DATA_WIDTH*PPC  pixel i at bits [i*DW +: DW].
s_axis_gray_tuser  in  1  start of frame.
s_axis_gray_tlast  in  1  end of line.
s_axis_gray_tready  out  1  input ready (registered).
m_axis_yuv_tvalid  out  1  output valid (registered).
m_axis_yuv_tdata  out  OUT_W  OUT_W = (PAD_TO_3?3:2)*DW*PPC.
m_axis_yuv_tuser  out  1  start of frame.
m_axis_yuv_tlast  out  1  end of line.
m_axis_yuv_tready  in  1  downstream ready.
frame_count  out  16  count of SOF beats accepted at the output.
err_short_line  out  1  sticky flag; LINE_CHECK feature only.
err_long_line  out  1  sticky flag; LINE_CHECK feature only.
cfg_line_beats  in  LINE_BEATS_W  expected beats per line; LINE_CHECK feature only.
err_clear  in  1  clears sticky errors; LINE_CHECK feature only.

Behaviour:
- Clock and reset: single clock aclk. Reset areset is asynchronous, active-high, and is deasserted synchronously by the system.
- Reset values: m_axis_yuv_tvalid=0, tdata=0, tuser=0, tlast=0; s_axis_gray_tready=0 while areset is high, then 1 on the first clock after release. frame_count=0, latched chroma=CHROMA_RESET, error flags=0, beat counter=0.
- Packing, per pixel i: Y = gray_i at bits [2i*DW +: DW]; C = chroma at bits [(2i+1)*DW +: DW]. Bits above 2*DW*PPC are 0.
- Chroma selection: a beat with tuser=1 uses cfg_chroma sampled in that same cycle. That value is held for all later beats until the next SOF.
- Buffer states:
  - EMPTY: output register not valid.
  - ONE: output register valid, skid empty.
  - TWO: output register and skid both full.
- Transitions:
  - EMPTY + in accept -> ONE.
  - ONE + in accept + out accept -> ONE (pass-through).
  - ONE + in accept, no out accept -> TWO.
  - ONE + out accept, no in accept -> EMPTY.
  - TWO + out accept -> ONE; skid moves to the output register.
- Ready: s_axis_gray_tready = registered (state != TWO), so tready never depends combinationally on m_axis_yuv_tready.
- Latency and throughput: latency is 1 cycle from input accept to m_tvalid. Throughput is 1 beat per clock with continuous ready.
- Data integrity: no beat is lost or duplicated under any valid/ready pattern. Output tdata/tuser/tlast stay stable while m_tvalid=1 and m_tready=0.
- frame_count increments on each output handshake with tuser=1 and wraps from 0xFFFF to 0.
- Mid-stream reset: everything returns to reset values immediately. Any buffered beats are discarded.

Optional Feature:
- Macro: GRAY_TO_YUV422_LINE_CHECK_EN.
- With the macro: a beat counter counts output handshakes within a line and resets on tuser or after tlast.
  - On a tlast beat with count+1 < cfg_line_beats: set err_short_line.
  - On reaching cfg_line_beats beats without tlast: set err_long_line. It is set once per line.
  - Both flags are sticky until err_clear=1 for one cycle. If err_clear and a set event occur in the same cycle, set wins.
- Without the macro: no counter logic; err_short_line and err_long_line are tied to 0; cfg_line_beats and err_clear are ignored.

Test Plan:
1. Reset, then send gray beat 0x40302010 with m_tready=1 (DW=8, PPC=4, PAD_TO_3=1) -> one cycle later tdata = 0x…80_40_80_30_80_20_80_10 with the upper 32 bits zero, and m_tvalid=1 for exactly 1 cycle.
2. SOF beat with cfg_chroma=0x55, then 3 more beats with cfg_chroma=0x99 -> all 4 output beats carry C=0x55; frame_count goes 0→1.
3. Continuous input, m_tready toggling 1,0,0,1,1,0 -> s_tready drops only in TWO state; the output sequence equals the input sequence exactly, with no stalls when m_tready=1.
4. Assert areset while in state TWO -> m_tvalid=0 immediately, s_tready=0; after release, the first new beat appears with CHROMA_RESET=0x80.
5. LINE_CHECK_EN, cfg_line_beats=4: a line of 3 beats with tlast gives err_short_line=1; a line of 5 beats gives err_long_line=1 at beat 4; err_clear returns both to 0.
6. 65536 SOF beats -> frame_count wraps to 0.

Source files
------------

// File: rtl/gray_to_yuv422_reg.sv
// gray_to_yuv422_reg
// Registered grayscale to YUV422 packer for the Format_Conv video path.
// Each PPC-pixel gray beat becomes Y/C pairs (Y from gray, C from a chroma
// value latched on every start-of-frame beat). A two-entry skid buffer
// registers both tdata and tready so neither path is combinational.
// A 16-bit frame counter counts SOF beats leaving the block.
// Optional line-length checking is compiled in when the macro
// GRAY_TO_YUV422_LINE_CHECK_EN is defined; otherwise the error flags are 0.
module gray_to_yuv422_reg #(
    parameter int DATA_WIDTH   = 8,
    parameter int PPC          = 4,
    parameter int PAD_TO_3     = 1,
    parameter int CHROMA_RESET = 2**(DATA_WIDTH-1),
    parameter int LINE_BEATS_W = 12
) (
    input  logic                                              aclk,
    input  logic                                              areset,
    input  logic [DATA_WIDTH-1:0]                             cfg_chroma,
    input  logic                                              s_axis_gray_tvalid,
    input  logic [DATA_WIDTH*PPC-1:0]                         s_axis_gray_tdata,
    input  logic                                              s_axis_gray_tuser,
    input  logic                                              s_axis_gray_tlast,
    output logic                                              s_axis_gray_tready,
    output logic                                              m_axis_yuv_tvalid,
    output logic [((PAD_TO_3 != 0) ? 3 : 2)*DATA_WIDTH*PPC-1:0] m_axis_yuv_tdata,
    output logic                                              m_axis_yuv_tuser,
    output logic                                              m_axis_yuv_tlast,
    input  logic                                              m_axis_yuv_tready,
    output logic [15:0]                                       frame_count,
    output logic                                              err_short_line,
    output logic                                              err_long_line,
    input  logic [LINE_BEATS_W-1:0]                           cfg_line_beats,
    input  logic                                              err_clear
);

    localparam int IN_W   = DATA_WIDTH * PPC;
    localparam int PACK_W = 2 * IN_W;
    localparam int OUT_W  = ((PAD_TO_3 != 0) ? 3 : 2) * IN_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

    buf_state_t              r_state;
    buf_state_t              w_nextState;
    logic                    r_sReady;
    logic [PACK_W-1:0]       r_outData;
    logic [PACK_W-1:0]       r_skidData;
    logic [PACK_W-1:0]       w_packed;
    logic                    r_outUser;
    logic                    r_outLast;
    logic                    r_skidUser;
    logic                    r_skidLast;
    logic [DATA_WIDTH-1:0]   r_chroma;
    logic [DATA_WIDTH-1:0]   w_chroma;
    logic [15:0]             r_frameCount;
    logic                    w_mValid;
    logic                    w_inAcc;
    logic                    w_outAcc;

    assign w_mValid = (r_state != ST_EMPTY);
    assign w_inAcc  = s_axis_gray_tvalid & r_sReady;
    assign w_outAcc = w_mValid & m_axis_yuv_tready;

    // Pack the incoming beat; an SOF beat uses the live cfg_chroma directly
    always_comb begin
        w_chroma = s_axis_gray_tuser ? cfg_chroma : r_chroma;
        w_packed = '0;
        for (int i = 0; i < PPC; i++) begin
            w_packed[2*i*DATA_WIDTH +: DATA_WIDTH]     = s_axis_gray_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            w_packed[(2*i+1)*DATA_WIDTH +: DATA_WIDTH] = w_chroma;
        end
    end

    // Hold the chroma of the current frame until the next accepted SOF beat
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_chroma <= DATA_WIDTH'(CHROMA_RESET);
        end else if (w_inAcc && s_axis_gray_tuser) begin
            r_chroma <= cfg_chroma;
        end
    end

    // Buffer occupancy register; ready is registered from the next occupancy
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state  <= ST_EMPTY;
            r_sReady <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_sReady <= (w_nextState != ST_TWO);
        end
    end

    // Occupancy transitions from the input and output handshakes
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_EMPTY: if (w_inAcc) w_nextState = ST_ONE;
            ST_ONE: begin
                if (w_inAcc && !w_outAcc) begin
                    w_nextState = ST_TWO;
                end else if (!w_inAcc && w_outAcc) begin
                    w_nextState = ST_EMPTY;
                end
            end
            ST_TWO:   if (w_outAcc) w_nextState = ST_ONE;
            default:  w_nextState = ST_EMPTY;
        endcase
    end

    // Output and skid registers; the output only changes when empty or consumed
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_outData  <= '0;
            r_outUser  <= 1'b0;
            r_outLast  <= 1'b0;
            r_skidData <= '0;
            r_skidUser <= 1'b0;
            r_skidLast <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_inAcc) begin
                        r_outData <= w_packed;
                        r_outUser <= s_axis_gray_tuser;
                        r_outLast <= s_axis_gray_tlast;
                    end
                end
                ST_ONE: begin
                    if (w_inAcc && w_outAcc) begin
                        r_outData <= w_packed;
                        r_outUser <= s_axis_gray_tuser;
                        r_outLast <= s_axis_gray_tlast;
                    end else if (w_inAcc) begin
                        r_skidData <= w_packed;
                        r_skidUser <= s_axis_gray_tuser;
                        r_skidLast <= s_axis_gray_tlast;
                    end
                end
                ST_TWO: begin
                    if (w_outAcc) begin
                        r_outData <= r_skidData;
                        r_outUser <= r_skidUser;
                        r_outLast <= r_skidLast;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Count SOF beats as they leave the block; wraps naturally at 16 bits
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_frameCount <= '0;
        end else if (w_outAcc && r_outUser) begin
            r_frameCount <= r_frameCount + 16'd1;
        end
    end

    assign s_axis_gray_tready = r_sReady;
    assign m_axis_yuv_tvalid  = w_mValid;
    assign m_axis_yuv_tuser   = r_outUser;
    assign m_axis_yuv_tlast   = r_outLast;
    assign frame_count        = r_frameCount;

    generate
        if (PAD_TO_3 != 0) begin : g_pad
            assign m_axis_yuv_tdata = {{(OUT_W-PACK_W){1'b0}}, r_outData};
        end else begin : g_nopad
            assign m_axis_yuv_tdata = r_outData;
        end
    endgenerate

`ifdef GRAY_TO_YUV422_LINE_CHECK_EN
    logic [LINE_BEATS_W-1:0] r_beatCnt;
    logic                    r_longSeen;
    logic                    r_errShort;
    logic                    r_errLong;
    logic [LINE_BEATS_W-1:0] w_curCnt;
    logic [LINE_BEATS_W-1:0] w_nextCnt;
    logic                    w_curLong;
    logic                    w_setShort;
    logic                    w_setLong;

    // Position of the departing beat in its line; an SOF beat starts a new line
    always_comb begin
        w_curCnt   = r_outUser ? '0 : r_beatCnt;
        w_curLong  = r_outUser ? 1'b0 : r_longSeen;
        w_nextCnt  = (&w_curCnt) ? w_curCnt : w_curCnt + LINE_BEATS_W'(1);
        w_setShort = w_outAcc && r_outLast && (w_nextCnt < cfg_line_beats);
        w_setLong  = w_outAcc && !r_outLast && !w_curLong && (w_nextCnt == cfg_line_beats);
    end

    // Beat counter, once-per-line long marker and sticky flags (set beats clear)
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_beatCnt  <= '0;
            r_longSeen <= 1'b0;
            r_errShort <= 1'b0;
            r_errLong  <= 1'b0;
        end else begin
            if (w_outAcc) begin
                if (r_outLast) begin
                    r_beatCnt  <= '0;
                    r_longSeen <= 1'b0;
                end else begin
                    r_beatCnt  <= w_nextCnt;
                    r_longSeen <= w_curLong | w_setLong;
                end
            end
            if (w_setShort) begin
                r_errShort <= 1'b1;
            end else if (err_clear) begin
                r_errShort <= 1'b0;
            end
            if (w_setLong) begin
                r_errLong <= 1'b1;
            end else if (err_clear) begin
                r_errLong <= 1'b0;
            end
        end
    end

    assign err_short_line = r_errShort;
    assign err_long_line  = r_errLong;
`else
    logic w_unusedLineCfg;

    assign w_unusedLineCfg = ^{cfg_line_beats, err_clear};
    assign err_short_line  = 1'b0;
    assign err_long_line   = 1'b0;
`endif

endmodule

// File: tb/tb_gray_to_yuv422_reg.sv
// Scoreboard bench for gray_to_yuv422_reg (DATA_WIDTH=8, PPC=4, PAD_TO_3=1).
// A negedge monitor pushes the expected packed beat on every input handshake
// and pops/compares on every output handshake, while also checking ready,
// valid, output hold during stalls and the frame counter.
module tb_gray_to_yuv422_reg;

    localparam int DW  = 8;
    localparam int PPC = 4;
    localparam int OW  = 3 * DW * PPC;
    localparam int LBW = 12;

    typedef struct packed {
        logic [OW-1:0] data;
        logic          user;
        logic          last;
    } beat_t;

    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic [DW-1:0]   cfgChroma = 8'h00;
    logic            sValid = 1'b0;
    logic [DW*PPC-1:0] sData = '0;
    logic            sUser = 1'b0;
    logic            sLast = 1'b0;
    logic            sReady;
    logic            mValid;
    logic [OW-1:0]   mData;
    logic            mUser;
    logic            mLast;
    logic            mReady = 1'b1;
    logic [15:0]     frameCount;
    logic            errShort;
    logic            errLong;
    logic [LBW-1:0]  cfgLineBeats = 12'd4;
    logic            errClear = 1'b0;

    int     errors = 0;
    int     checks = 0;
    beat_t  sb[$];
    logic   armed = 1'b0;
    logic   bulkMode = 1'b0;
    int     bulkOut = 0;
    logic [15:0] modelFrames = 16'd0;
    logic [DW-1:0] modelChroma = 8'h80;
    logic   prevStall = 1'b0;
    logic [OW+1:0] prevWord = '0;
    int     readyMode = 0;
    int     patIdx = 0;
    logic [5:0] readyPattern = 6'b011001;
    logic   expShort;
    logic   expLong;

    gray_to_yuv422_reg #(
        .DATA_WIDTH(DW),
        .PPC(PPC),
        .PAD_TO_3(1),
        .CHROMA_RESET(128),
        .LINE_BEATS_W(LBW)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .cfg_chroma(cfgChroma),
        .s_axis_gray_tvalid(sValid),
        .s_axis_gray_tdata(sData),
        .s_axis_gray_tuser(sUser),
        .s_axis_gray_tlast(sLast),
        .s_axis_gray_tready(sReady),
        .m_axis_yuv_tvalid(mValid),
        .m_axis_yuv_tdata(mData),
        .m_axis_yuv_tuser(mUser),
        .m_axis_yuv_tlast(mLast),
        .m_axis_yuv_tready(mReady),
        .frame_count(frameCount),
        .err_short_line(errShort),
        .err_long_line(errLong),
        .cfg_line_beats(cfgLineBeats),
        .err_clear(errClear)
    );

    always #5 aclk = ~aclk;

    // Count one comparison and report it when observed differs from expected
    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference packing: Y at even component slots, chroma at odd, upper third zero
    function automatic logic [OW-1:0] packExp(input logic [DW*PPC-1:0] g, input logic [DW-1:0] c);
        logic [OW-1:0] r;
        r = '0;
        for (int i = 0; i < PPC; i++) begin
            r[2*i*DW +: DW]     = g[i*DW +: DW];
            r[(2*i+1)*DW +: DW] = c;
        end
        return r;
    endfunction

    // Downstream ready generator: steady, fixed toggle pattern, random, or stalled
    always @(posedge aclk) begin
        #1;
        case (readyMode)
            0: mReady = 1'b1;
            1: begin
                mReady = readyPattern[patIdx];
                patIdx = (patIdx + 1) % 6;
            end
            2: mReady = 1'($urandom_range(0, 1));
            default: mReady = 1'b0;
        endcase
    end

    // Monitor and scoreboard, sampled mid-cycle
    always @(negedge aclk) begin
        beat_t e;
        beat_t x;
        if (areset) begin
            sb.delete();
            modelChroma = 8'h80;
            modelFrames = 16'd0;
            prevStall = 1'b0;
        end else if (bulkMode) begin
            if (mValid && mReady) bulkOut++;
        end else if (armed) begin
            checkOutput("s_tready", sReady, (sb.size() != 2));
            checkOutput("m_tvalid", mValid, (sb.size() != 0));
            checkOutput("frame_count", frameCount, modelFrames);
            if (prevStall) checkOutput("hold_while_stalled", {mUser, mLast, mData}, prevWord);
            if (mValid && mReady) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    x = sb.pop_front();
                    checkOutput("tdata", mData, x.data);
                    checkOutput("tuser", mUser, x.user);
                    checkOutput("tlast", mLast, x.last);
                    if (x.user) modelFrames = modelFrames + 16'd1;
                end
            end
            prevStall = mValid && !mReady;
            prevWord = {mUser, mLast, mData};
            if (sValid && sReady) begin
                if (sUser) modelChroma = cfgChroma;
                e.data = packExp(sData, modelChroma);
                e.user = sUser;
                e.last = sLast;
                sb.push_back(e);
            end
        end
    end

    // Drive one beat and hold it until accepted (bounded wait)
    task automatic applyStimulus(input logic [DW*PPC-1:0] g, input logic u, input logic l, input logic [DW-1:0] c);
        logic accepted;
        accepted = 1'b0;
        sValid = 1'b1;
        sData = g;
        sUser = u;
        sLast = l;
        cfgChroma = c;
        for (int w = 0; w < 200; w++) begin
            @(negedge aclk);
            if (sReady) begin
                accepted = 1'b1;
                break;
            end
            @(posedge aclk);
            #1;
        end
        if (!accepted) checkOutput("s_tready_timeout", 1'b0, 1'b1);
        @(posedge aclk);
        #1;
        sValid = 1'b0;
        sUser = 1'b0;
        sLast = 1'b0;
    endtask

    // Wait until every accepted beat has left the block (bounded)
    task automatic drainOutput();
        logic empty;
        empty = 1'b0;
        for (int w = 0; w < 200; w++) begin
            @(negedge aclk);
            if (sb.size() == 0 && !mValid) begin
                empty = 1'b1;
                break;
            end
        end
        if (!empty) checkOutput("drain_timeout", 1'b0, 1'b1);
        @(posedge aclk);
        #1;
    endtask

    // Hold reset for a few cycles, release it, and arm the monitor once ready rises
    task automatic resetDut();
        armed = 1'b0;
        sValid = 1'b0;
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;
        @(posedge aclk);
        #1;
        armed = 1'b1;
    endtask

    initial begin
        int accepted;
        $display("[TB] start");
`ifdef GRAY_TO_YUV422_LINE_CHECK_EN
        expShort = 1'b1;
        expLong  = 1'b1;
`else
        expShort = 1'b0;
        expLong  = 1'b0;
`endif
        // Reset values while reset is held
        @(posedge aclk);
        #1;
        checkOutput("rst_s_tready", sReady, 1'b0);
        checkOutput("rst_m_tvalid", mValid, 1'b0);
        checkOutput("rst_tdata", mData, '0);
        checkOutput("rst_tuser_tlast", {mUser, mLast}, 2'b00);
        checkOutput("rst_frame_count", frameCount, 16'd0);
        checkOutput("rst_err_flags", {errShort, errLong}, 2'b00);
        resetDut();
        checkOutput("rst_release_ready", sReady, 1'b1);

        // Single beat, reset chroma, valid for exactly one cycle
        readyMode = 0;
        applyStimulus(32'h40302010, 1'b0, 1'b0, 8'hAA);
        @(negedge aclk);
        checkOutput("t1_tdata", mData, 96'h0000_0000_8040_8030_8020_8010);
        checkOutput("t1_valid_on", mValid, 1'b1);
        @(negedge aclk);
        checkOutput("t1_valid_off", mValid, 1'b0);
        @(posedge aclk);
        #1;

        // SOF chroma latched for the rest of the frame
        applyStimulus(32'h11223344, 1'b1, 1'b0, 8'h55);
        applyStimulus(32'h55667788, 1'b0, 1'b0, 8'h99);
        applyStimulus(32'h99AABBCC, 1'b0, 1'b0, 8'h99);
        applyStimulus(32'hDDEEFF00, 1'b0, 1'b1, 8'h99);
        @(negedge aclk);
        checkOutput("t2_last_beat", mData, 96'h0000_0000_55DD_55EE_55FF_5500);
        @(posedge aclk);
        #1;
        drainOutput();
        checkOutput("t2_frame_count", frameCount, 16'd1);

        // Streaming under a fixed ready toggle pattern, then random ready and gaps
        readyMode = 1;
        for (int i = 0; i < 24; i++) begin
            applyStimulus($urandom, (i % 8) == 0, (i % 6) == 5, 8'($urandom));
        end
        drainOutput();
        readyMode = 2;
        for (int i = 0; i < 32; i++) begin
            applyStimulus($urandom, (i % 10) == 0, (i % 4) == 3, 8'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge aclk);
                #1;
            end
        end
        readyMode = 0;
        drainOutput();

        // Reset while both buffer entries are full
        readyMode = 3;
        @(posedge aclk);
        #1;
        applyStimulus(32'hA1A2A3A4, 1'b1, 1'b0, 8'h21);
        applyStimulus(32'hB1B2B3B4, 1'b0, 1'b0, 8'h22);
        @(negedge aclk);
        checkOutput("t4_full_ready", sReady, 1'b0);
        @(posedge aclk);
        #1;
        armed = 1'b0;
        areset = 1'b1;
        #1;
        checkOutput("t4_valid_cleared", mValid, 1'b0);
        checkOutput("t4_ready_cleared", sReady, 1'b0);
        checkOutput("t4_tdata_cleared", mData, '0);
        checkOutput("t4_frame_cleared", frameCount, 16'd0);
        readyMode = 0;
        resetDut();
        applyStimulus(32'h04030201, 1'b0, 1'b0, 8'h33);
        @(negedge aclk);
        checkOutput("t4_chroma_reset", mData, 96'h0000_0000_8004_8003_8002_8001);
        @(posedge aclk);
        #1;
        drainOutput();

        // Line length checking with 4 beats per line
        cfgLineBeats = 12'd4;
        applyStimulus(32'h01010101, 1'b1, 1'b0, 8'h40);
        applyStimulus(32'h02020202, 1'b0, 1'b0, 8'h40);
        applyStimulus(32'h03030303, 1'b0, 1'b1, 8'h40);
        drainOutput();
        checkOutput("t5_short_set", errShort, expShort);
        checkOutput("t5_short_no_long", errLong, 1'b0);
        errClear = 1'b1;
        @(posedge aclk);
        #1;
        errClear = 1'b0;
        checkOutput("t5_clear_short", {errShort, errLong}, 2'b00);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h10101010 + i, i == 0, i == 3, 8'h41);
        end
        drainOutput();
        checkOutput("t5_exact_line", {errShort, errLong}, 2'b00);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h20202020 + i, i == 0, 1'b0, 8'h42);
        end
        drainOutput();
        checkOutput("t5_long_not_yet", errLong, 1'b0);
        applyStimulus(32'h20202023, 1'b0, 1'b0, 8'h42);
        drainOutput();
        checkOutput("t5_long_at_beat4", errLong, expLong);
        applyStimulus(32'h20202024, 1'b0, 1'b1, 8'h42);
        drainOutput();
        checkOutput("t5_long_no_short", errShort, 1'b0);
        checkOutput("t5_long_held", errLong, expLong);
        errClear = 1'b1;
        @(posedge aclk);
        #1;
        errClear = 1'b0;
        checkOutput("t5_clear_long", {errShort, errLong}, 2'b00);

        // Frame counter wrap over 65536 SOF beats
        resetDut();
        bulkMode = 1'b1;
        bulkOut = 0;
        accepted = 0;
        sValid = 1'b1;
        sUser = 1'b1;
        sLast = 1'b1;
        sData = 32'hCAFEF00D;
        for (int c = 0; c < 70000 && accepted < 65535; c++) begin
            @(negedge aclk);
            if (sReady) accepted++;
            @(posedge aclk);
            #1;
        end
        sValid = 1'b0;
        sUser = 1'b0;
        sLast = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("t6_beats_65535", bulkOut, 65535);
        checkOutput("t6_count_ffff", frameCount, 16'hFFFF);
        applyStimulus(32'hCAFEF00D, 1'b1, 1'b1, 8'h00);
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("t6_beats_65536", bulkOut, 65536);
        checkOutput("t6_count_wrap", frameCount, 16'd0);
        bulkMode = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
